// File: rtl/sequence_pattern_generator_pkg.sv
// Shared FSM state encodings and the default stimulus pattern for the
// sequence pattern generator and its matching detector/bench.
package sequence_pattern_generator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_shift_register.sv
// Pattern holding register: parallel load, rotate-left by one, MSB tap.
// Cleared asynchronously by the active-low reset.
module pattern_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             rotate,
    input  logic [WIDTH-1:0] load_value,
    output logic             msb
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Load wins over rotate; after WIDTH rotations the original pattern is back.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_value;
        end else if (rotate) begin
            shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/sequence_pattern_generator.sv
// Serial MSB-first pattern transmitter, repeat_count+1 back-to-back emissions.
// Define GAP_INSERT_EN to insert one idle-low GAP cycle between repetitions.
module sequence_pattern_generator
    import sequence_pattern_generator_pkg::*;
#(
    parameter int PATTERN_W = 4,
    parameter int REPEAT_W  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [REPEAT_W-1:0]  repeat_count,
    output logic                 sequence_out,
    output logic                 bit_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(PATTERN_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PATTERN_W - 1);

    state_e               state_q, state_d;
    logic [REPEAT_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 seq_out_q, seq_out_d;
    logic                 bit_valid_q, bit_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 load_sr;
    logic                 rotate_sr;
    logic                 sr_msb;

    pattern_shift_register #(
        .WIDTH(PATTERN_W)
    ) u_shreg (
        .clock      (clock),
        .reset      (reset),
        .load       (load_sr),
        .rotate     (rotate_sr),
        .load_value (pattern_in),
        .msb        (sr_msb)
    );

    always_comb begin
        state_d     = state_q;
        rep_cnt_d   = rep_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        load_sr     = 1'b0;
        rotate_sr   = 1'b0;
        seq_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_sr   = 1'b1;
                    rep_cnt_d = repeat_count;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy_d    = 1'b1;
                bit_cnt_d = LAST_BIT;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                seq_out_d   = sr_msb;
                bit_valid_d = 1'b1;
                busy_d      = 1'b1;
                rotate_sr   = 1'b1;
                // Counting rep_cnt down to zero lets all-ones give 2**REPEAT_W passes without overflow.
                if (bit_cnt_q == '0) begin
                    if (rep_cnt_q != '0) begin
                        rep_cnt_d = rep_cnt_q - REPEAT_W'(1);
                        bit_cnt_d = LAST_BIT;
`ifdef GAP_INSERT_EN
                        state_d   = ST_GAP;
`endif
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
`ifdef GAP_INSERT_EN
            ST_GAP: begin
                busy_d  = 1'b1;
                state_d = ST_SHIFT;
            end
`endif
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the current state and registered, so the line
    // shows each phase one cycle after the FSM enters it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rep_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            seq_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_cnt_q   <= rep_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            seq_out_q   <= seq_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sequence_out = seq_out_q;
    assign bit_valid    = bit_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
